// File: rtl/prbs_test_sequencer.sv
// rtl/prbs_test_sequencer.sv - PRBS run sequencer: loads word/count, scores pass/timeout per run
// Optional seed rotation between runs: PRBS_SEQ_SEED_ROTATE_EN
module prbs_test_sequencer #(
    parameter int data_width       = 32,
    parameter int Repetitive_width = 8,
    parameter int RUNS_W           = 8,
    parameter int TIMEOUT          = 256
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic                        abort,
    input  logic [data_width-1:0]       cfg_word,
    input  logic [Repetitive_width-1:0] cfg_n,
    input  logic [RUNS_W-1:0]           cfg_runs,
    input  logic                        pattern_correct,
    output logic [data_width-1:0]       IN,
    output logic [Repetitive_width-1:0] N,
    output logic                        Valid,
    output logic                        busy,
    output logic                        done,
    output logic [RUNS_W-1:0]           pass_cnt,
    output logic [RUNS_W-1:0]           fail_cnt
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t                        state, state_n;
    logic [data_width-1:0]         word_q, word_n;
    logic [Repetitive_width-1:0]   n_q, n_n;
    logic [RUNS_W-1:0]             runs_q, runs_n;
    logic [RUNS_W-1:0]             run_cnt, run_n;
    logic [TW-1:0]                 timer, timer_n;
    logic                          pc_prev;
    logic                          pc_rise;
    logic [RUNS_W-1:0]             pass_n, fail_n;
    logic [data_width-1:0]         in_n;
    logic [Repetitive_width-1:0]   n_out_n;

    assign pc_rise = pattern_correct & ~pc_prev;

    always_comb begin
        state_n = state;
        word_n  = word_q;
        n_n     = n_q;
        runs_n  = runs_q;
        run_n   = run_cnt;
        timer_n = timer;
        pass_n  = pass_cnt;
        fail_n  = fail_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    word_n  = cfg_word;
                    n_n     = cfg_n;
                    runs_n  = cfg_runs;
                    run_n   = '0;
                    pass_n  = '0;
                    fail_n  = '0;
                    state_n = (cfg_runs == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // A pass wins over a timeout landing in the same cycle
                if (pc_rise) begin
                    pass_n  = (&pass_cnt) ? pass_cnt : pass_cnt + RUNS_W'(1);
                    state_n = S_NEXT;
                end else if (timer == T_LAST) begin
                    fail_n  = (&fail_cnt) ? fail_cnt : fail_cnt + RUNS_W'(1);
                    state_n = S_NEXT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_NEXT: begin
                if (run_cnt == runs_q - RUNS_W'(1)) begin
                    state_n = S_DONE;
                end else begin
                    run_n   = run_cnt + RUNS_W'(1);
`ifdef PRBS_SEQ_SEED_ROTATE_EN
                    word_n  = {word_q[data_width-2:0], word_q[data_width-1]};
`endif
                    state_n = S_LOAD;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            pass_n  = pass_cnt;
            fail_n  = fail_cnt;
        end
        // Outputs are registered from the next state so they line up with it
        in_n    = IN;
        n_out_n = N;
        if (state_n == S_LOAD) begin
            in_n    = word_n;
            n_out_n = n_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            word_q   <= '0;
            n_q      <= '0;
            runs_q   <= '0;
            run_cnt  <= '0;
            timer    <= '0;
            pc_prev  <= 1'b0;
            IN       <= '0;
            N        <= '0;
            Valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= state_n;
            word_q   <= word_n;
            n_q      <= n_n;
            runs_q   <= runs_n;
            run_cnt  <= run_n;
            timer    <= timer_n;
            pc_prev  <= pattern_correct;
            IN       <= in_n;
            N        <= n_out_n;
            Valid    <= (state_n == S_LOAD);
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
            pass_cnt <= pass_n;
            fail_cnt <= fail_n;
        end
    end

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// tb/tb_prbs_test_sequencer.sv - scoreboard bench for prbs_test_sequencer
module tb_prbs_test_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_word = '0;
    logic [7:0]  cfg_n = '0;
    logic [7:0]  cfg_runs = '0;
    logic        pattern_correct = 1'b0;
    logic [31:0] in_w;
    logic [7:0]  n_w;
    logic        valid_w, busy_w, done_w;
    logic [7:0]  pass_w, fail_w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [39:0] exp_load[$];
    logic [15:0] exp_done[$];

    prbs_test_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .cfg_word(cfg_word), .cfg_n(cfg_n), .cfg_runs(cfg_runs),
        .pattern_correct(pattern_correct),
        .IN(in_w), .N(n_w), .Valid(valid_w), .busy(busy_w), .done(done_w),
        .pass_cnt(pass_w), .fail_cnt(fail_w)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] next_word(input logic [31:0] w);
`ifdef PRBS_SEQ_SEED_ROTATE_EN
        return {w[30:0], w[31]};
`else
        return w;
`endif
    endfunction

    // Monitor: every Valid pulse and every done pulse is matched against the scoreboard
    initial begin
        logic [39:0] el;
        logic [15:0] ed;
        forever begin
            @(negedge CLK);
            if (valid_w) begin
                if (exp_load.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    el = exp_load.pop_front();
                    check("load_in_n", {in_w, n_w}, el);
                end
            end
            if (done_w) begin
                if (exp_done.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    ed = exp_done.pop_front();
                    check("done_counts", {pass_w, fail_w}, ed);
                    check("busy_in_done", busy_w, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid_or_done(output int cyc);
        cyc = 0;
        while (!valid_w && !done_w && cyc < 400) begin
            @(negedge CLK);
            cyc++;
        end
        if (cyc >= 400) check("wait_timeout", 1, 0);
    endtask

    task automatic run_seq(input logic [31:0] w, input logic [7:0] n, input logic [7:0] runs,
                           input logic [7:0] pass_mask, input logic [7:0] ep, input logic [7:0] ef);
        logic [31:0] cw;
        int cyc;
        cw = w;
        for (int r = 0; r < runs; r++) begin
            exp_load.push_back({cw, n});
            cw = next_word(cw);
        end
        exp_done.push_back({ep, ef});
        @(negedge CLK);
        cfg_word = w; cfg_n = n; cfg_runs = runs; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        if (runs == 0) check("zero_runs_done_cycle1", done_w, 1);
        for (int r = 0; r < runs; r++) begin
            wait_valid_or_done(cyc);
            if (pass_mask[r]) begin
                repeat (5) @(negedge CLK);
                pattern_correct = 1'b1;
                @(negedge CLK);
                pattern_correct = 1'b0;
            end else begin
                @(negedge CLK);
                wait_valid_or_done(cyc);
                check("fail_run_length", cyc + 1, 258);
            end
        end
        wait_valid_or_done(cyc);
        check("done_seen", done_w, 1);
        @(negedge CLK);
        check("busy_after_done", busy_w, 0);
        check("done_one_cycle", done_w, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_in", in_w, 0);
        check("rst_n", n_w, 0);
        check("rst_valid", valid_w, 0);
        check("rst_busy", busy_w, 0);
        check("rst_done", done_w, 0);
        check("rst_counts", {pass_w, fail_w}, 0);
        RST = 1'b1;

        // Basic pass
        run_seq(32'hA5A5_1234, 8'd4, 8'd1, 8'b1, 8'd1, 8'd0);
        // Timeout on every run
        run_seq(32'h0000_0001, 8'd2, 8'd3, 8'b0, 8'd0, 8'd3);
        // Mixed pass/fail, seed rotation when enabled
        run_seq(32'h8000_0001, 8'd9, 8'd4, 8'b0101, 8'd2, 8'd2);
        // Zero runs
        run_seq(32'h1234_5678, 8'd1, 8'd0, 8'b0, 8'd0, 8'd0);
        // Stale high level must not count as a pass
        pattern_correct = 1'b1;
        repeat (2) @(negedge CLK);
        run_seq(32'h0000_0055, 8'd3, 8'd1, 8'b0, 8'd0, 8'd1);
        pattern_correct = 1'b0;

        // Abort in WAIT of run 1 of 3
        begin
            int cyc;
            exp_load.push_back({32'h0000_00F0, 8'd7});
            exp_load.push_back({next_word(32'h0000_00F0), 8'd7});
            @(negedge CLK);
            cfg_word = 32'h0000_00F0; cfg_n = 8'd7; cfg_runs = 8'd3; start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            repeat (5) @(negedge CLK);
            pattern_correct = 1'b1;
            @(negedge CLK);
            pattern_correct = 1'b0;
            wait_valid_or_done(cyc);
            check("abort_run1_valid", valid_w, 1);
            repeat (3) @(negedge CLK);
            abort = 1'b1;
            @(negedge CLK);
            abort = 1'b0;
            check("abort_busy", busy_w, 0);
            check("abort_valid", valid_w, 0);
            check("abort_counts_held", {pass_w, fail_w}, {8'd1, 8'd0});
            repeat (5) @(negedge CLK);
            check("abort_no_done_counts", {pass_w, fail_w}, {8'd1, 8'd0});
        end
        // Restart after abort clears counters
        run_seq(32'h0000_00F0, 8'd7, 8'd2, 8'b00, 8'd0, 8'd2);

        // Reset in the middle of WAIT
        exp_load.push_back({32'hDEAD_BEEF, 8'd6});
        @(negedge CLK);
        cfg_word = 32'hDEAD_BEEF; cfg_n = 8'd6; cfg_runs = 8'd2; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre_reset_busy", busy_w, 1);
        check("pre_reset_in", in_w, 32'hDEAD_BEEF);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("mid_rst_in", in_w, 0);
        check("mid_rst_n", n_w, 0);
        check("mid_rst_busy", busy_w, 0);
        check("mid_rst_counts", {pass_w, fail_w}, 0);
        repeat (10) @(negedge CLK);
        check("mid_rst_still_idle", busy_w, 0);

        check("load_queue_empty", exp_load.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
